// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared size/fault encodings and controller state type for the RAM access path
package mem_pkg;

  // Access size field (ReqMS[1:0] / MS_2_0[1:0])
  localparam logic [1:0] MS_BYTE = 2'b00;
  localparam logic [1:0] MS_HALF = 2'b01;
  localparam logic [1:0] MS_WORD = 2'b10;
  localparam logic [1:0] MS_INV  = 2'b11;

  // Completion fault codes
  localparam logic [1:0] FLT_NONE    = 2'b00;
  localparam logic [1:0] FLT_ALIGN   = 2'b01;
  localparam logic [1:0] FLT_SIZE    = 2'b10;
  localparam logic [1:0] FLT_TIMEOUT = 2'b11;

  typedef enum logic [1:0] {
    ST_FLUSH,
    ST_IDLE,
    ST_ACCESS,
    ST_RELEASE
  } mem_state_t;

endpackage

// File: rtl/mem_req_check.sv
// rtl/mem_req_check.sv - combinational size/alignment check for a load/store request
module mem_req_check
  import mem_pkg::*;
(
  input  logic [1:0] size,
  input  logic [1:0] addr_lo,
  output logic       fault,
  output logic [1:0] code
);

  // Invalid size wins over alignment; bytes can never be misaligned
  always_comb begin
    fault = 1'b0;
    code  = FLT_NONE;
    case (size)
      MS_INV: begin
        fault = 1'b1;
        code  = FLT_SIZE;
      end
      MS_HALF: begin
        if (addr_lo[0]) begin
          fault = 1'b1;
          code  = FLT_ALIGN;
        end
      end
      MS_WORD: begin
        if (addr_lo != 2'b00) begin
          fault = 1'b1;
          code  = FLT_ALIGN;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - load/store sequencer for ram256x8_c; MEM_TIMEOUT_EN adds an ACCESS timeout
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        Req,
  input  logic        ReqRW,
  input  logic [2:0]  ReqMS,
  input  logic [31:0] ReqAddr,
  input  logic [31:0] ReqWrData,
  output logic        Busy,
  output logic        Done,
  output logic        Fault,
  output logic [1:0]  FaultCode,
  output logic [31:0] RdData,
  output logic        MOV,
  output logic        ReadWrite,
  output logic        MOCoff,
  output logic [2:0]  MS_2_0,
  output logic [31:0] Address,
  output logic [31:0] DataIn,
  input  logic        MOC,
  input  logic [31:0] DataOut
);

  mem_state_t  state, state_nx;
  logic        mov_nx, mocoff_nx, busy_nx, done_nx, fault_nx, rw_nx;
  logic        tmo_flt, tmo_flt_nx, tmo_hit;
  logic [2:0]  ms_nx;
  logic [1:0]  fc_nx;
  logic [31:0] addr_nx, din_nx, rd_nx;
  logic        chk_fault;
  logic [1:0]  chk_code;

  mem_req_check u_check (
    .size    (ReqMS[1:0]),
    .addr_lo (ReqAddr[1:0]),
    .fault   (chk_fault),
    .code    (chk_code)
  );

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] acc_cnt;

  // Count cycles spent waiting in ACCESS; cleared in every other state
  always_ff @(posedge Clk) begin
    if (!Reset_n)
      acc_cnt <= '0;
    else if (state == ST_ACCESS)
      acc_cnt <= acc_cnt + CNT_W'(1);
    else
      acc_cnt <= '0;
  end

  assign tmo_hit = (state == ST_ACCESS) && (acc_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  // The timeout length only matters when the timeout build is selected
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT_CYCLES != 0);
  assign tmo_hit    = 1'b0;
`endif

  // Next-state and next-output decode; everything holds unless a transition fires
  always_comb begin
    state_nx   = state;
    mov_nx     = MOV;
    mocoff_nx  = MOCoff;
    busy_nx    = Busy;
    done_nx    = 1'b0;
    fault_nx   = 1'b0;
    fc_nx      = FaultCode;
    rw_nx      = ReadWrite;
    ms_nx      = MS_2_0;
    addr_nx    = Address;
    din_nx     = DataIn;
    rd_nx      = RdData;
    tmo_flt_nx = tmo_flt;
    case (state)
      ST_FLUSH: begin
        if (!MOC) begin
          state_nx  = ST_IDLE;
          mocoff_nx = 1'b0;
          busy_nx   = 1'b0;
        end else begin
          busy_nx   = 1'b1;
        end
      end
      ST_IDLE: begin
        if (Req) begin
          if (chk_fault) begin
            done_nx  = 1'b1;
            fault_nx = 1'b1;
            fc_nx    = chk_code;
          end else begin
            state_nx   = ST_ACCESS;
            mov_nx     = 1'b1;
            busy_nx    = 1'b1;
            rw_nx      = ReqRW;
            ms_nx      = ReqMS;
            addr_nx    = ReqAddr;
            din_nx     = ReqWrData;
            tmo_flt_nx = 1'b0;
          end
        end
      end
      ST_ACCESS: begin
        if (MOC) begin
          if (ReadWrite)
            rd_nx = DataOut;
          state_nx  = ST_RELEASE;
          mov_nx    = 1'b0;
          mocoff_nx = 1'b1;
        end else if (tmo_hit) begin
          state_nx   = ST_RELEASE;
          mov_nx     = 1'b0;
          mocoff_nx  = 1'b1;
          tmo_flt_nx = 1'b1;
        end
      end
      ST_RELEASE: begin
        if (!MOC) begin
          state_nx  = ST_IDLE;
          mocoff_nx = 1'b0;
          busy_nx   = 1'b0;
          done_nx   = 1'b1;
          fault_nx  = tmo_flt;
          fc_nx     = tmo_flt ? FLT_TIMEOUT : FLT_NONE;
        end
      end
      default: ;
    endcase
  end

  // State and every output are registered; reset abandons any access in flight
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state     <= ST_FLUSH;
      MOCoff    <= 1'b1;
      MOV       <= 1'b0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      Fault     <= 1'b0;
      FaultCode <= FLT_NONE;
      RdData    <= '0;
      ReadWrite <= 1'b0;
      MS_2_0    <= '0;
      Address   <= '0;
      DataIn    <= '0;
      tmo_flt   <= 1'b0;
    end else begin
      state     <= state_nx;
      MOCoff    <= mocoff_nx;
      MOV       <= mov_nx;
      Busy      <= busy_nx;
      Done      <= done_nx;
      Fault     <= fault_nx;
      FaultCode <= fc_nx;
      RdData    <= rd_nx;
      ReadWrite <= rw_nx;
      MS_2_0    <= ms_nx;
      Address   <= addr_nx;
      DataIn    <= din_nx;
      tmo_flt   <= tmo_flt_nx;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - randomized self-checking bench for mem_access_ctrl with a behavioural RAM
module tb_mem_access_ctrl;

  localparam int TMO = 4;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        Req = 1'b0;
  logic        ReqRW = 1'b0;
  logic [2:0]  ReqMS = 3'b000;
  logic [31:0] ReqAddr = 32'h0;
  logic [31:0] ReqWrData = 32'h0;
  logic        Busy, Done, Fault, MOV, ReadWrite, MOCoff;
  logic [1:0]  FaultCode;
  logic [2:0]  MS_2_0;
  logic [31:0] RdData, Address, DataIn;
  logic        MOC = 1'b0;
  logic [31:0] DataOut = 32'h0;

  int n_checks = 0;
  int n_fail = 0;

  logic [7:0]  ram [256];
  logic [7:0]  exp_mem [256];
  logic [31:0] exp_rd = 32'h0;
  int          acc_delay = 0, rel_delay = 0, acc_wait = 0, rel_wait = 0;
  bit          ram_stall = 1'b0;

  mem_access_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Req(Req), .ReqRW(ReqRW), .ReqMS(ReqMS),
    .ReqAddr(ReqAddr), .ReqWrData(ReqWrData), .Busy(Busy), .Done(Done), .Fault(Fault),
    .FaultCode(FaultCode), .RdData(RdData), .MOV(MOV), .ReadWrite(ReadWrite),
    .MOCoff(MOCoff), .MS_2_0(MS_2_0), .Address(Address), .DataIn(DataIn),
    .MOC(MOC), .DataOut(DataOut)
  );

  always #5 Clk = ~Clk;

  // Big-endian byte RAM: performs the access and raises MOC, drops MOC once MOCoff is seen
  task automatic ram_do();
    int a;
    logic [31:0] v;
    a = int'(Address[7:0]);
    if (ReadWrite) begin
      case (MS_2_0[1:0])
        2'b00:   v = MS_2_0[2] ? {{24{ram[a][7]}}, ram[a]} : {24'h0, ram[a]};
        2'b01: begin
          v = {16'h0, ram[a], ram[(a+1)%256]};
          if (MS_2_0[2]) v[31:16] = {16{ram[a][7]}};
        end
        default: v = {ram[a], ram[(a+1)%256], ram[(a+2)%256], ram[(a+3)%256]};
      endcase
      DataOut = v;
    end else begin
      case (MS_2_0[1:0])
        2'b00: ram[a] = DataIn[7:0];
        2'b01: begin ram[a] = DataIn[15:8]; ram[(a+1)%256] = DataIn[7:0]; end
        default: begin
          ram[a] = DataIn[31:24]; ram[(a+1)%256] = DataIn[23:16];
          ram[(a+2)%256] = DataIn[15:8]; ram[(a+3)%256] = DataIn[7:0];
        end
      endcase
    end
  endtask

  always begin
    @(posedge Clk);
    #3;
    if (MOV === 1'b1 && !MOC) begin
      if (acc_wait > 0) acc_wait--;
      else if (!ram_stall) begin
        ram_do();
        MOC = 1'b1;
        rel_wait = rel_delay;
      end
    end else if (MOCoff === 1'b1 && MOC) begin
      if (rel_wait > 0) rel_wait--;
      else MOC = 1'b0;
    end
    if (MOV !== 1'b1 && !MOC) acc_wait = acc_delay;
  end

  // Reference model: bytes per size, fault rule, read/write on a shadow memory
  function automatic int ref_size(input logic [2:0] ms);
    return 1 << ms[1:0];
  endfunction

  function automatic logic [1:0] ref_fault(input logic [31:0] a, input logic [2:0] ms);
    if (ms[1:0] == 2'b11) return 2'b10;
    if ((int'(a[7:0]) % ref_size(ms)) != 0) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [31:0] ref_read(input int a, input logic [2:0] ms);
    int n;
    logic [31:0] v;
    n = ref_size(ms);
    v = 32'h0;
    for (int i = 0; i < n; i++) v = (v << 8) | 32'(exp_mem[(a + i) % 256]);
    if (ms[2] && n < 4 && v[8*n-1]) v = v | ~((32'h1 << (8*n)) - 32'h1);
    return v;
  endfunction

  task automatic ref_write(input int a, input logic [2:0] ms, input logic [31:0] wd);
    int n;
    n = ref_size(ms);
    for (int i = 0; i < n; i++) exp_mem[(a + i) % 256] = 8'(wd >> (8 * (n - 1 - i)));
  endtask

  // One request from IDLE: checks RAM-side controls, latency, fault, RdData and Done pulse width
  task automatic run_req(input logic rw, input logic [2:0] ms, input logic [31:0] addr,
                         input logic [31:0] wd, input int d, input int r, input bit tmo,
                         input string tag);
    logic [1:0] exp_fc;
    int exp_lat, lat;
    bit mov_seen, is_chk_fault;
    exp_fc = tmo ? 2'b11 : ref_fault(addr, ms);
    is_chk_fault = (exp_fc == 2'b01 || exp_fc == 2'b10);
    exp_lat = is_chk_fault ? 1 : (tmo ? TMO + 2 : 3 + d + r);
    @(negedge Clk);
    acc_delay = d; acc_wait = d; rel_delay = r; ram_stall = tmo;
    Req = 1'b1; ReqRW = rw; ReqMS = ms; ReqAddr = addr; ReqWrData = wd;
    @(posedge Clk);
    #1;
    Req = 1'b0; ReqAddr = $urandom; ReqWrData = $urandom; ReqMS = 3'($urandom); ReqRW = 1'($urandom);
    lat = 0; mov_seen = 1'b0;
    while (lat < 60) begin
      @(negedge Clk);
      lat++;
      if (MOV === 1'b1) begin
        mov_seen = 1'b1;
        n_checks++;
        if ({ReadWrite, MS_2_0, Address, DataIn, MOCoff} !== {rw, ms, addr, wd, 1'b0}) begin
          n_fail++;
          $display("FAIL %s ram_ctrl: got rw=%b ms=%b addr=%h din=%h mocoff=%b, want rw=%b ms=%b addr=%h din=%h mocoff=0",
                   tag, ReadWrite, MS_2_0, Address, DataIn, MOCoff, rw, ms, addr, wd);
        end
      end
      if (Done === 1'b1) break;
    end
    n_checks++;
    if (Done !== 1'b1 || lat != exp_lat) begin
      n_fail++;
      $display("FAIL %s latency: got done=%b after %0d cycles, want done=1 after %0d", tag, Done, lat, exp_lat);
    end
    n_checks++;
    if (Fault !== (exp_fc != 2'b00)) begin
      n_fail++;
      $display("FAIL %s fault: got %b want %b", tag, Fault, (exp_fc != 2'b00));
    end
    n_checks++;
    if (FaultCode !== exp_fc) begin
      n_fail++;
      $display("FAIL %s fault_code: got %b want %b", tag, FaultCode, exp_fc);
    end
    if (exp_fc == 2'b00) begin
      if (rw) exp_rd = ref_read(int'(addr[7:0]), ms);
      else ref_write(int'(addr[7:0]), ms, wd);
    end
    n_checks++;
    if (RdData !== exp_rd) begin
      n_fail++;
      $display("FAIL %s rd_data: got %h want %h", tag, RdData, exp_rd);
    end
    n_checks++;
    if (mov_seen != !is_chk_fault) begin
      n_fail++;
      $display("FAIL %s mov_activity: got %b want %b", tag, mov_seen, !is_chk_fault);
    end
    @(negedge Clk);
    n_checks++;
    if (Done !== 1'b0 || Busy !== 1'b0 || FaultCode !== exp_fc) begin
      n_fail++;
      $display("FAIL %s after_done: got done=%b busy=%b code=%b, want done=0 busy=0 code=%b",
               tag, Done, Busy, FaultCode, exp_fc);
    end
  endtask

  task automatic test_reset();
    Reset_n = 1'b0; Req = 1'b0; MOC = 1'b0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    n_checks++;
    if ({MOCoff, MOV, Busy, Done, Fault} !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got mocoff,mov,busy,done,fault=%b want 10000", {MOCoff, MOV, Busy, Done, Fault});
    end
    n_checks++;
    if ({FaultCode, RdData, Address, DataIn, MS_2_0, ReadWrite} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got code=%b rd=%h addr=%h din=%h ms=%b rw=%b want all zero",
               FaultCode, RdData, Address, DataIn, MS_2_0, ReadWrite);
    end
    Reset_n = 1'b1;
    @(negedge Clk);
    n_checks++;
    if ({MOCoff, MOV, Busy, Done} !== 4'b0000) begin
      n_fail++;
      $display("FAIL flush_exit: got mocoff,mov,busy,done=%b want 0000", {MOCoff, MOV, Busy, Done});
    end
  endtask

  task automatic test_word_rw();
    run_req(1'b0, 3'b010, 32'h10, 32'hDEADBEEF, 0, 0, 1'b0, "word_write");
    run_req(1'b1, 3'b010, 32'h10, 32'h0, 0, 0, 1'b0, "word_read");
    n_checks++;
    if (RdData !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL word_value: got %h want deadbeef", RdData);
    end
  endtask

  task automatic test_signed_byte();
    run_req(1'b0, 3'b000, 32'h21, 32'h00000080, 0, 0, 1'b0, "byte_write");
    run_req(1'b1, 3'b100, 32'h21, 32'h0, 0, 0, 1'b0, "byte_read_signed");
    n_checks++;
    if (RdData !== 32'hFFFFFF80) begin
      n_fail++;
      $display("FAIL signed_byte: got %h want ffffff80", RdData);
    end
    run_req(1'b1, 3'b000, 32'h21, 32'h0, 0, 0, 1'b0, "byte_read_unsigned");
    n_checks++;
    if (RdData !== 32'h00000080) begin
      n_fail++;
      $display("FAIL unsigned_byte: got %h want 00000080", RdData);
    end
  endtask

  task automatic test_align_faults();
    run_req(1'b1, 3'b001, 32'h03, 32'h0, 0, 0, 1'b0, "half_misaligned");
    run_req(1'b0, 3'b010, 32'h06, 32'h12345678, 0, 0, 1'b0, "word_misaligned");
    run_req(1'b1, 3'b011, 32'h08, 32'h0, 0, 0, 1'b0, "invalid_size");
    run_req(1'b1, 3'b001, 32'h22, 32'h0, 0, 0, 1'b0, "half_aligned");
  endtask

  task automatic test_back_to_back();
    int lat, rises;
    logic prev_mov;
    @(negedge Clk);
    acc_delay = 2; acc_wait = 2; rel_delay = 0; ram_stall = 1'b0;
    Req = 1'b1; ReqRW = 1'b0; ReqMS = 3'b010; ReqAddr = 32'h40; ReqWrData = 32'h11223344;
    @(posedge Clk);
    #1;
    ReqAddr = 32'h44; ReqWrData = 32'h55667788;
    lat = 0; rises = 0; prev_mov = 1'b0;
    while (lat < 60) begin
      @(negedge Clk);
      lat++;
      if (MOV === 1'b1 && !prev_mov) rises++;
      prev_mov = MOV;
      if (Done === 1'b1) break;
      if (MOV === 1'b1) begin
        n_checks++;
        if (Address !== 32'h40 || DataIn !== 32'h11223344) begin
          n_fail++;
          $display("FAIL busy_stable: got addr=%h din=%h want 00000040 11223344", Address, DataIn);
        end
      end
    end
    n_checks++;
    if (Done !== 1'b1 || lat != 5 || rises != 1 || Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_first: got done=%b lat=%0d rises=%0d busy=%b want 1 5 1 0", Done, lat, rises, Busy);
    end
    @(negedge Clk);
    n_checks++;
    if (MOV !== 1'b1 || Done !== 1'b0 || Address !== 32'h44 || DataIn !== 32'h55667788) begin
      n_fail++;
      $display("FAIL done_cycle_req: got mov=%b done=%b addr=%h din=%h want 1 0 00000044 55667788",
               MOV, Done, Address, DataIn);
    end
    Req = 1'b0;
    lat = 0;
    while (lat < 60 && Done !== 1'b1) begin
      @(negedge Clk);
      lat++;
    end
    n_checks++;
    if (Done !== 1'b1 || Fault !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_second: got done=%b fault=%b want 1 0", Done, Fault);
    end
    ref_write(32'h40, 3'b010, 32'h11223344);
    ref_write(32'h44, 3'b010, 32'h55667788);
    run_req(1'b1, 3'b010, 32'h40, 32'h0, 0, 0, 1'b0, "readback_40");
    n_checks++;
    if (RdData !== 32'h11223344) begin
      n_fail++;
      $display("FAIL readback_40_value: got %h want 11223344", RdData);
    end
    run_req(1'b1, 3'b010, 32'h44, 32'h0, 1, 1, 1'b0, "readback_44");
    n_checks++;
    if (RdData !== 32'h55667788) begin
      n_fail++;
      $display("FAIL readback_44_value: got %h want 55667788", RdData);
    end
  endtask

  task automatic test_reset_mid_access();
    int n;
    bit seen_done, seen_mov;
    logic prev_moc;
    @(negedge Clk);
    acc_delay = 0; acc_wait = 0; rel_delay = 3; ram_stall = 1'b0;
    Req = 1'b1; ReqRW = 1'b1; ReqMS = 3'b010; ReqAddr = 32'h10; ReqWrData = 32'h0;
    @(posedge Clk);
    #1;
    Req = 1'b0;
    @(negedge Clk);
    n_checks++;
    if (MOV !== 1'b1 || Busy !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_access_start: got mov=%b busy=%b want 1 1", MOV, Busy);
    end
    Reset_n = 1'b0;
    @(negedge Clk);
    n_checks++;
    if (MOV !== 1'b0 || MOCoff !== 1'b1 || Done !== 1'b0 || RdData !== 32'h0) begin
      n_fail++;
      $display("FAIL mid_access_reset: got mov=%b mocoff=%b done=%b rd=%h want 0 1 0 00000000",
               MOV, MOCoff, Done, RdData);
    end
    exp_rd = 32'h0;
    Reset_n = 1'b1;
    n = 0; seen_done = 1'b0; seen_mov = 1'b0; prev_moc = MOC;
    while (n < 40) begin
      @(negedge Clk);
      n++;
      if (Done === 1'b1) seen_done = 1'b1;
      if (MOV === 1'b1) seen_mov = 1'b1;
      if (MOCoff === 1'b0) break;
      prev_moc = MOC;
    end
    n_checks++;
    if (MOCoff !== 1'b0 || prev_moc !== 1'b0 || n != 1 + 3 || seen_done || seen_mov) begin
      n_fail++;
      $display("FAIL flush_wait: got mocoff=%b moc_before=%b cycles=%0d done=%b mov=%b want 0 0 4 0 0",
               MOCoff, prev_moc, n, seen_done, seen_mov);
    end
    rel_delay = 0;
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout();
    run_req(1'b1, 3'b010, 32'h10, 32'h0, 0, 0, 1'b0, "pre_timeout_read");
    run_req(1'b1, 3'b010, 32'h20, 32'h0, 0, 0, 1'b1, "timeout");
    ram_stall = 1'b0;
  endtask
`endif

  task automatic test_random();
    logic [2:0]  ms;
    logic [31:0] addr;
    int n;
    for (int i = 0; i < 40; i++) begin
      ms = 3'($urandom);
      addr = 32'($urandom_range(0, 255));
      n = ref_size(ms);
      if (ms[1:0] != 2'b11 && $urandom_range(0, 3) != 0) addr = addr & ~32'(n - 1);
      run_req(1'($urandom), ms, addr, $urandom, $urandom_range(0, 2), $urandom_range(0, 2), 1'b0, "random");
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i] = 8'($urandom);
      exp_mem[i] = ram[i];
    end
    test_reset();
    test_word_rw();
    test_signed_byte();
    test_align_faults();
    test_back_to_back();
    test_reset_mid_access();
`ifdef MEM_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Clocked request sequencer between the datapath/control unit and the asynchronous byte-addressed RAM (`ram256x8_c`). It accepts one load/store request at a time and checks size and alignment. It drives the RAM's `MOV`/`ReadWrite`/`MS_2_0`/`Address`/`DataIn` handshake, waits for `MOC`, and registers read data. It then clears `MOC` via `MOCoff` before reporting completion.

## Interface
- `TIMEOUT_CYCLES`, default 16: maximum cycles in ACCESS before a timeout fault. Used only with `MEM_TIMEOUT_EN`.
- `Clk` in 1: single clock, rising edge.
- `Reset_n` in 1: synchronous, active-low reset (sampled on `Clk`).
- `Req` in 1: datapath request; sampled only in IDLE.
- `ReqRW` in 1: 1 = read, 0 = write (RAM `ReadWrite` polarity).
- `ReqMS` in 3: `[1:0]` size (00 byte, 01 halfword, 10 word, 11 invalid); `[2]` sign-extend for reads.
- `ReqAddr` in 32: byte address.
- `ReqWrData` in 32: store data, right-justified.
- `Busy` out 1: high in every state except IDLE.
- `Done` out 1: one-cycle completion pulse, success or fault.
- `Fault` out 1: qualifies `Done`; 1 = access not (fully) performed.
- `FaultCode` out 2: 00 none, 01 misaligned, 10 invalid size, 11 timeout. Held until the next `Done`.
- `RdData` out 32: registered read result. Updated only on a successful read and held otherwise.
- `MOV`, `ReadWrite`, `MOCoff` out 1 each: RAM controls.
- `MS_2_0` out 3: RAM control.
- `Address`, `DataIn` out 32 each: RAM controls.
- `MOC` in 1: from the RAM.
- `DataOut` in 32: from the RAM.

## Operation
- States: FLUSH, IDLE, ACCESS, RELEASE. All outputs are registered (Moore).
- **FLUSH** (entered on reset):
  - Outputs: `MOCoff`=1, `MOV`=0.
  - Go to IDLE at the first edge where `MOC`=0. No `Done` is issued.
- **IDLE** (`MOCoff`=0, `MOV`=0):
  - On `Req`=1, check the request:
    - `ReqMS[1:0]`=11 gives fault code 10.
    - Halfword with `ReqAddr[0]`=1 gives fault code 01.
    - Word with `ReqAddr[1:0]`≠00 gives fault code 01.
  - On a fault: no RAM access, state stays IDLE, and `Done`=`Fault`=1 next cycle.
  - Otherwise: latch `ReqRW`/`ReqMS`/`ReqAddr`/`ReqWrData` into `ReadWrite`/`MS_2_0`/`Address`/`DataIn`, then go to ACCESS.
- **ACCESS** (`MOV`=1):
  - Address, data and control stay stable for the whole state.
  - When `MOC` is sampled 1: for a read, capture `DataOut` into `RdData`. Then go to RELEASE.
- **RELEASE** (`MOV`=0, `MOCoff`=1):
  - When `MOC` is sampled 0, go to IDLE.
  - Pulse `Done` in the first IDLE cycle. `Fault`=0 unless the access timed out.
- `Req` is ignored while `Busy`. A `Req` in the same cycle as `Done` (IDLE) is accepted.
- Sign extension is performed by the RAM. This block passes `ReqMS[2]` through unchanged.

## Timing
- Reset values: state FLUSH; `MOCoff`=1; all other outputs 0 (`RdData`=0, `FaultCode`=00).
- Reset mid-operation: `MOV` drops at that edge and the state enters FLUSH. The access in flight is abandoned with no `Done`.
- Minimum successful latency, with `Req` sampled at edge 0:
  - ACCESS from edge 0.
  - `MOC` sampled high at edge 1; RELEASE.
  - `MOC` sampled low at edge 2; IDLE.
  - `Done` high in the cycle after edge 2, i.e. 3 cycles `Req`→`Done`.
- Fault from the IDLE checks: `Done` high in the cycle after the `Req` edge (1-cycle latency).
- `RdData` is valid no later than the `Done` cycle and stays valid until the next successful read.
- `MOV` and `MOCoff` are never both 1.

## Configuration
- `MEM_TIMEOUT_EN` defined:
  - A counter of width $clog2(`TIMEOUT_CYCLES`+1) increments each ACCESS cycle.
  - If `TIMEOUT_CYCLES` ACCESS cycles elapse without `MOC`, go to RELEASE with `FaultCode`=11.
  - `Done`+`Fault` then follow as normal, and `RdData` is unchanged.
- `MEM_TIMEOUT_EN` undefined: no counter; ACCESS waits indefinitely for `MOC`. `TIMEOUT_CYCLES` is unused.

## Structure
- Shared package `mem_pkg`:
  - Size encodings `MS_BYTE`/`MS_HALF`/`MS_WORD`/`MS_INV`.
  - Fault codes `FLT_NONE`/`FLT_ALIGN`/`FLT_SIZE`/`FLT_TIMEOUT`.
  - State enum `mem_state_t`.
- One sub-module, `mem_req_check`: combinational size/alignment check producing fault-valid and code. Reused later by the fetch path.

## Test plan
- Word write then read: write 0xDEADBEEF to 0x10, then read word at 0x10 → `RdData`=0xDEADBEEF, `Fault`=0, each transaction `Done` 3 cycles after `Req`.
- Signed byte read: memory[0x21]=0x80, `ReqMS`=100 → `RdData`=0xFFFFFF80; with `ReqMS`=000 → `RdData`=0x00000080.
- Alignment faults:
  - Halfword at 0x03 → `Done`=`Fault`=1 one cycle later, `FaultCode`=01, `MOV` never high.
  - Word at 0x06 → same response.
  - `ReqMS`=011 → `FaultCode`=10.
- Request while `Busy`: a second `Req` held high during ACCESS is ignored. The `Req` still high in the `Done` cycle starts a new access, so `MOV` rises one cycle later.
- Reset mid-access: drive `Reset_n`=0 during ACCESS → `MOV`=0 and `MOCoff`=1 after that edge, no `Done`, and IDLE is reached only after `MOC`=0.
- Timeout (`MEM_TIMEOUT_EN`, `TIMEOUT_CYCLES`=4): RAM model holds `MOC`=0 → RELEASE after 4 ACCESS cycles, `Done`=`Fault`=1, `FaultCode`=11, `RdData` unchanged.
